sram_burst_ctrl: RTL and testbench

- Initiator for the single-port RAM with chip-select, output-enable and write-enable, and asynchronous read.
- Accepts burst read/write commands on a valid/ready command channel. Streams write data in and read data out over valid/ready channels.
- Sequences the RAM pins (cs/oe/we/address/din) and captures dout. Sits between a DMA/bus client and the RAM macro.

---
 rtl/sram_burst_ctrl_pkg.sv | 15 +
 rtl/sram_burst_addr_cnt.sv | 49 ++++
 rtl/sram_burst_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_burst_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and default widths for the SRAM burst initiator.
package sram_burst_ctrl_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_ADDRESS_WIDTH = 8;
   localparam int DEF_LEN_WIDTH     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_RD_ADDR = 2'd2,
      ST_RD_HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/sram_burst_addr_cnt.sv
// Burst address incrementer and beats-remaining down-counter.
// last_o flags the final beat (no beats left after the current one).
module sram_burst_addr_cnt #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int LEN_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_i,
   input  logic                     step_i,
   input  logic [ADDRESS_WIDTH-1:0] load_addr_i,
   input  logic [LEN_WIDTH-1:0]     load_len_i,
   output logic [ADDRESS_WIDTH-1:0] addr_o,
   output logic                     last_o
);

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]     CNT_ONE  = LEN_WIDTH'(1);

   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;

   // Address wraps naturally modulo 2^ADDRESS_WIDTH.
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = load_addr_i;
         cnt_d  = load_len_i;
      end else if (step_i) begin
         addr_d = addr_q + ADDR_ONE;
         cnt_d  = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst read/write initiator for a single-port asynchronous-read SRAM.
//   state      | meaning
//   ST_IDLE    | cmd_ready high, waiting for a command
//   ST_WRITE   | streaming write beats, one RAM write per wr handshake
//   ST_RD_ADDR | address driven with cs/oe, dout captured at the edge
//   ST_RD_HOLD | read beat presented, RAM deselected until rd_ready
module sram_burst_ctrl
   import sram_burst_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int LEN_WIDTH     = DEF_LEN_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]     cmd_len,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_last,
   output logic                     mem_cs,
   output logic                     mem_oe,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_din,
   input  logic [DATA_WIDTH-1:0]    mem_dout
);

   state_e                   state_q;
   logic [DATA_WIDTH-1:0]    rd_data_q;
   logic                     rd_last_q;
   logic [ADDRESS_WIDTH-1:0] burst_addr;
   logic                     burst_last;
   logic                     cmd_hs;
   logic                     wr_hs;
   logic                     rd_hs;
   logic                     step;

   assign cmd_hs = (state_q == ST_IDLE)    && cmd_valid;
   assign wr_hs  = (state_q == ST_WRITE)   && wr_valid;
   assign rd_hs  = (state_q == ST_RD_HOLD) && rd_ready;
   // The final read handshake leaves the address untouched; only non-last beats advance.
   assign step   = wr_hs || (rd_hs && !rd_last_q);

   sram_burst_addr_cnt #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .LEN_WIDTH     (LEN_WIDTH)
   ) u_addr_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (cmd_hs),
      .step_i      (step),
      .load_addr_i (cmd_addr),
      .load_len_i  (cmd_len),
      .addr_o      (burst_addr),
      .last_o      (burst_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rd_data_q <= '0;
         rd_last_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state_q <= cmd_write ? ST_WRITE : ST_RD_ADDR;
               end
            end
            ST_WRITE: begin
               if (wr_valid && burst_last) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RD_ADDR: begin
               rd_data_q <= mem_dout;
               rd_last_q <= burst_last;
               state_q   <= ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
               if (rd_ready) begin
                  state_q <= rd_last_q ? ST_IDLE : ST_RD_ADDR;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Pin decode: oe and we live in disjoint states, so they can never overlap.
   always_comb begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      rd_valid  = 1'b0;
      mem_cs    = 1'b0;
      mem_oe    = 1'b0;
      mem_we    = 1'b0;
      mem_din   = '0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
         end
         ST_WRITE: begin
            wr_ready = 1'b1;
            mem_cs   = 1'b1;
            mem_we   = wr_valid;
            mem_din  = wr_data;
         end
         ST_RD_ADDR: begin
            mem_cs = 1'b1;
            mem_oe = 1'b1;
         end
         ST_RD_HOLD: begin
            rd_valid = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   assign mem_address = burst_addr;
   assign rd_data     = rd_data_q;
   assign rd_last     = rd_last_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed, table-driven bench for sram_burst_ctrl with a behavioural async-read RAM.
module tb_sram_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       rd_valid, rd_ready, rd_last;
   logic [7:0] rd_data;
   logic       mem_cs, mem_oe, mem_we;
   logic [7:0] mem_address, mem_din, mem_dout;

   logic [7:0] ram [0:255];

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   sram_burst_ctrl #(
      .DATA_WIDTH    (8),
      .ADDRESS_WIDTH (8),
      .LEN_WIDTH     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .rd_last     (rd_last),
      .mem_cs      (mem_cs),
      .mem_oe      (mem_oe),
      .mem_we      (mem_we),
      .mem_address (mem_address),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout)
   );

   always @(posedge clk) begin
      if (mem_cs && mem_we) ram[mem_address] <= mem_din;
   end
   assign mem_dout = ram[mem_address];

   // Pin invariants, sampled mid-cycle once inputs have settled.
   always @(negedge clk) begin
      #2;
      if (rst_n !== 1'bx && ((mem_oe && mem_we) || (!mem_cs && (mem_oe || mem_we)))) begin
         $display("FAIL pin_invariant cs=%b oe=%b we=%b at %0t", mem_cs, mem_oe, mem_we, $time);
         nmis++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst_n;
      logic       cv;
      logic       cw;
      logic [7:0] ca;
      logic [3:0] cl;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic [2:0] hs;     // {cmd_ready, wr_ready, rd_valid}
      logic [2:0] pins;   // {mem_cs, mem_oe, mem_we}
      logic [7:0] ad;
      logic [7:0] rd;
      logic       rl;
      logic       chk_rd;
   } vec_t;

   vec_t vq[$];

   task automatic push(input logic r, input logic cv, input logic cw, input logic [7:0] ca,
                       input logic [3:0] cl, input logic wv, input logic [7:0] wd, input logic rr,
                       input logic [2:0] hs, input logic [2:0] pins, input logic [7:0] ad,
                       input logic [7:0] rd, input logic rl, input logic chk);
      vec_t v;
      v.rst_n = r;  v.cv = cv;   v.cw = cw; v.ca = ca; v.cl = cl;
      v.wv = wv;    v.wd = wd;   v.rr = rr; v.hs = hs; v.pins = pins;
      v.ad = ad;    v.rd = rd;   v.rl = rl; v.chk_rd = chk;
      vq.push_back(v);
   endtask

   task automatic idle(input logic cv, input logic cw, input logic [7:0] ca, input logic [3:0] cl);
      push(1'b1, cv, cw, ca, cl, 1'b0, 8'h00, 1'b0, 3'b100, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic wv, input logic [7:0] wd, input logic [7:0] ad);
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, wv, wd, 1'b0, 3'b010, {2'b10, wv}, ad, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic ra(input logic rr, input logic [7:0] ad);
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, rr, 3'b000, 3'b110, ad, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic rh(input logic rr, input logic [7:0] rd, input logic rl);
      push(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, rr, 3'b001, 3'b000, 8'h00, rd, rl, 1'b0);
   endtask

   task automatic check_vec(input vec_t e, input int idx);
      nvec++;
      if ({cmd_ready, wr_ready, rd_valid} !== e.hs) begin
         $display("FAIL vec%0d handshake {cmd_ready,wr_ready,rd_valid} got %b want %b",
                  idx, {cmd_ready, wr_ready, rd_valid}, e.hs);
         nmis++;
      end
      if ({mem_cs, mem_oe, mem_we} !== e.pins) begin
         $display("FAIL vec%0d pins {cs,oe,we} got %b want %b", idx, {mem_cs, mem_oe, mem_we}, e.pins);
         nmis++;
      end
      if (e.pins[2] && mem_address !== e.ad) begin
         $display("FAIL vec%0d mem_address got %h want %h", idx, mem_address, e.ad);
         nmis++;
      end
      if (e.pins[0] && mem_din !== e.wd) begin
         $display("FAIL vec%0d mem_din got %h want %h", idx, mem_din, e.wd);
         nmis++;
      end
      if ((e.hs[0] || e.chk_rd) && {rd_data, rd_last} !== {e.rd, e.rl}) begin
         $display("FAIL vec%0d rd_data/rd_last got %h/%b want %h/%b", idx, rd_data, rd_last, e.rd, e.rl);
         nmis++;
      end
   endtask

   task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         $display("FAIL %s got %0h want %0h", name, got, want);
         nmis++;
      end
   endtask

   initial begin
      int k;
      logic [7:0] chk_addr [12];
      logic [7:0] chk_data [12];

      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
      wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;

      // Reset values while rst_n is still low.
      push(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 3'b100, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
      // Write burst 0x10 len 3, back-to-back.
      idle(1'b1, 1'b1, 8'h10, 4'd3);
      wr(1'b1, 8'hA0, 8'h10); wr(1'b1, 8'hA1, 8'h11); wr(1'b1, 8'hA2, 8'h12); wr(1'b1, 8'hA3, 8'h13);
      // Read it back with rd_ready held high.
      idle(1'b1, 1'b0, 8'h10, 4'd3);
      ra(1'b1, 8'h10); rh(1'b1, 8'hA0, 1'b0); ra(1'b1, 8'h11); rh(1'b1, 8'hA1, 1'b0);
      ra(1'b1, 8'h12); rh(1'b1, 8'hA2, 1'b0); ra(1'b1, 8'h13); rh(1'b1, 8'hA3, 1'b1);
      // Write with wr_valid gaps.
      idle(1'b1, 1'b1, 8'h20, 4'd1);
      wr(1'b0, 8'h00, 8'h20); wr(1'b1, 8'h5A, 8'h20); wr(1'b0, 8'h00, 8'h21); wr(1'b1, 8'hC3, 8'h21);
      // Read with a 5-cycle rd_ready stall on the first beat.
      idle(1'b1, 1'b0, 8'h20, 4'd1);
      ra(1'b0, 8'h20);
      for (int i = 0; i < 5; i++) rh(1'b0, 8'h5A, 1'b0);
      rh(1'b1, 8'h5A, 1'b0); ra(1'b1, 8'h21); rh(1'b1, 8'hC3, 1'b1);
      // Address wrap write and read-back.
      idle(1'b1, 1'b1, 8'hFE, 4'd3);
      wr(1'b1, 8'h11, 8'hFE); wr(1'b1, 8'h22, 8'hFF); wr(1'b1, 8'h33, 8'h00); wr(1'b1, 8'h44, 8'h01);
      idle(1'b1, 1'b0, 8'hFE, 4'd3);
      ra(1'b1, 8'hFE); rh(1'b1, 8'h11, 1'b0); ra(1'b1, 8'hFF); rh(1'b1, 8'h22, 1'b0);
      ra(1'b1, 8'h00); rh(1'b1, 8'h33, 1'b0); ra(1'b1, 8'h01); rh(1'b1, 8'h44, 1'b1);
      // Single-beat read, with the next write command already offered during the read beat.
      idle(1'b1, 1'b0, 8'h00, 4'd0);
      ra(1'b1, 8'h00); rh(1'b1, 8'h33, 1'b1);
      vq[vq.size()-1].cv = 1'b1; vq[vq.size()-1].cw = 1'b1; vq[vq.size()-1].ca = 8'h01;
      idle(1'b1, 1'b1, 8'h01, 4'd0);
      wr(1'b1, 8'h99, 8'h01);
      // Reset for 3 cycles in the middle of a write burst.
      idle(1'b1, 1'b1, 8'h40, 4'd3);
      wr(1'b1, 8'hE0, 8'h40); wr(1'b0, 8'h00, 8'h41);
      vq[vq.size()-1].rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         idle(1'b1, 1'b1, 8'h50, 4'd3);
         vq[vq.size()-1].rst_n = 1'b0; vq[vq.size()-1].wv = 1'b1;
         vq[vq.size()-1].wd = 8'hE1;   vq[vq.size()-1].chk_rd = 1'b1;
      end
      idle(1'b0, 1'b0, 8'h00, 4'd0);
      vq[vq.size()-1].chk_rd = 1'b1;
      idle(1'b1, 1'b0, 8'h40, 4'd1);
      ra(1'b1, 8'h40); rh(1'b1, 8'hE0, 1'b0); ra(1'b1, 8'h41); rh(1'b1, 8'h00, 1'b1);
      idle(1'b1, 1'b0, 8'h01, 4'd0);
      ra(1'b1, 8'h01); rh(1'b1, 8'h99, 1'b1);
      idle(1'b0, 1'b0, 8'h00, 4'd0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst_n = vq[i].rst_n; cmd_valid = vq[i].cv; cmd_write = vq[i].cw;
         cmd_addr = vq[i].ca; cmd_len = vq[i].cl;
         wr_valid = vq[i].wv; wr_data = vq[i].wd; rd_ready = vq[i].rr;
         #1;
         check_vec(vq[i], i);
      end

      // Maximum-length (16-beat) write burst at 0x80.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h80; cmd_len = 4'hF;
      #1;
      expect_eq("burst16_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'h30 + i);
         #1;
         expect_eq("burst16_wr_beat", {29'd0, wr_ready, mem_we, 1'b0} | {24'd0, mem_address} << 8,
                   {29'd0, 1'b1, 1'b1, 1'b0} | {24'd0, 8'(8'h80 + i)} << 8);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      #1;
      expect_eq("burst16_wr_done", {30'd0, cmd_ready, wr_ready}, {30'd0, 1'b1, 1'b0});

      // Read it back; each beat bounded by a cycle budget.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h80; cmd_len = 4'hF; rd_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 100 && k < 16; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         #1;
         if (rd_valid) begin
            expect_eq("burst16_rd_data", {24'd0, rd_data}, {24'd0, 8'(8'h30 + k)});
            expect_eq("burst16_rd_last", {31'd0, rd_last}, {31'd0, (k == 15)});
            k++;
         end
      end
      expect_eq("burst16_rd_beats", k, 16);
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      expect_eq("burst16_rd_done", {31'd0, cmd_ready}, 32'd1);

      // Final RAM contents.
      chk_addr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h40, 8'h41};
      chk_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h5A, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h99, 8'hE0, 8'h00};
      for (int i = 0; i < 12; i++) begin
         expect_eq($sformatf("ram_%h", chk_addr[i]), {24'd0, ram[chk_addr[i]]}, {24'd0, chk_data[i]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
